// File: rtl/e203_exu_longpwbck_mt.sv
// e203_exu_longpwbck_mt: per-thread long-pipe writeback buffers with round-robin retire to OITF.
// Optional retire counters: E203_LONGP_WBCK_STAT_EN.  Rev 1.0
`default_nettype none

module e203_exu_longpwbck_mt #(
  parameter int THREADS = 2,
  parameter int ITAG_W  = 1,
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       lsu_wbck_i_valid,
  output logic                       lsu_wbck_i_ready,
  input  logic [XLEN-1:0]            lsu_wbck_i_wdat,
  input  logic [ITAG_W-1:0]          lsu_wbck_i_itag,
  input  logic                       lsu_wbck_i_tid,
  input  logic                       lsu_wbck_i_err,
  input  logic [THREADS*ITAG_W-1:0]  oitf_ret_ptr,
  input  logic [THREADS*RFIDX_W-1:0] oitf_ret_rdidx,
  input  logic [THREADS-1:0]         oitf_ret_rdwen,
  input  logic [THREADS-1:0]         oitf_empty,
  output logic                       oitf_ret_ena,
  output logic [THREADS-1:0]         ret_thread_sel,
  output logic                       longp_wbck_o_valid,
  input  logic                       longp_wbck_o_ready,
  output logic [XLEN-1:0]            longp_wbck_o_wdat,
  output logic [RFIDX_W-1:0]         longp_wbck_o_rdidx,
  output logic                       longp_wbck_o_tid,
  output logic                       longp_excp_o_valid,
  input  logic                       longp_excp_o_ready,
  output logic                       longp_excp_o_tid
`ifdef E203_LONGP_WBCK_STAT_EN
  ,
  output logic [THREADS*16-1:0]      retire_cnt
`endif
);

  logic [THREADS-1:0] buf_vld_q;
  logic [THREADS-1:0] buf_err_q;
  logic [ITAG_W-1:0]  buf_itag_q [THREADS];
  logic [XLEN-1:0]    buf_wdat_q [THREADS];
  logic [ITAG_W-1:0]  ret_ptr_w  [THREADS];
  logic [RFIDX_W-1:0] rdidx_w    [THREADS];
  logic [THREADS-1:0] elig;

  logic rr_q;
  logic hold_q;
  logic hold_tid_q;
  logic gvld;
  logic gtid;
  logic out_req;
  logic complete;
  logic accept;

  assign lsu_wbck_i_ready = ~buf_vld_q[lsu_wbck_i_tid];
  assign accept           = lsu_wbck_i_valid & lsu_wbck_i_ready;

  generate
    for (genvar t = 0; t < THREADS; t++) begin : g_thr
      assign ret_ptr_w[t] = oitf_ret_ptr[t*ITAG_W +: ITAG_W];
      assign rdidx_w[t]   = oitf_ret_rdidx[t*RFIDX_W +: RFIDX_W];
      assign elig[t]      = buf_vld_q[t] & ~oitf_empty[t] & (buf_itag_q[t] == ret_ptr_w[t]);

      // A buffer cannot be refilled while occupied, so load and clear never collide.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          buf_vld_q[t]  <= 1'b0;
          buf_err_q[t]  <= 1'b0;
          buf_itag_q[t] <= '0;
          buf_wdat_q[t] <= '0;
        end else if (accept && (lsu_wbck_i_tid == 1'(t))) begin
          buf_vld_q[t]  <= 1'b1;
          buf_err_q[t]  <= lsu_wbck_i_err;
          buf_itag_q[t] <= lsu_wbck_i_itag;
          buf_wdat_q[t] <= lsu_wbck_i_wdat;
        end else if (complete && (gtid == 1'(t))) begin
          buf_vld_q[t]  <= 1'b0;
        end
      end

`ifdef E203_LONGP_WBCK_STAT_EN
      logic [15:0] cnt_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= 16'd0;
        end else if (oitf_ret_ena && ret_thread_sel[t]) begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
      assign retire_cnt[t*16 +: 16] = cnt_q;
`endif
    end
  endgenerate

  // A stalled request keeps its grant so a newly eligible thread cannot steal it.
  always_comb begin
    gvld = 1'b0;
    gtid = 1'b0;
    if (hold_q) begin
      gvld = elig[hold_tid_q];
      gtid = hold_tid_q;
    end else if (elig[rr_q]) begin
      gvld = 1'b1;
      gtid = rr_q;
    end else if (elig[~rr_q]) begin
      gvld = 1'b1;
      gtid = ~rr_q;
    end
  end

  assign out_req  = gvld & (buf_err_q[gtid] | oitf_ret_rdwen[gtid]);
  assign complete = gvld & (buf_err_q[gtid]      ? longp_excp_o_ready :
                            oitf_ret_rdwen[gtid] ? longp_wbck_o_ready : 1'b1);

  assign longp_excp_o_valid = gvld & buf_err_q[gtid];
  assign longp_excp_o_tid   = gtid;
  assign longp_wbck_o_valid = gvld & ~buf_err_q[gtid] & oitf_ret_rdwen[gtid];
  assign longp_wbck_o_wdat  = buf_wdat_q[gtid];
  assign longp_wbck_o_rdidx = rdidx_w[gtid];
  assign longp_wbck_o_tid   = gtid;

  assign oitf_ret_ena   = complete;
  assign ret_thread_sel = complete ? (THREADS'(1) << gtid) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= 1'b0;
      hold_q     <= 1'b0;
      hold_tid_q <= 1'b0;
    end else begin
      hold_q     <= out_req & ~complete;
      hold_tid_q <= gtid;
      if (complete) begin
        rr_q <= ~gtid;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_e203_exu_longpwbck_mt.sv
// Directed per-cycle vector bench for e203_exu_longpwbck_mt.
`default_nettype none

module tb_e203_exu_longpwbck_mt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_wbck_i_valid;
  logic        lsu_wbck_i_ready;
  logic [31:0] lsu_wbck_i_wdat;
  logic        lsu_wbck_i_itag;
  logic        lsu_wbck_i_tid;
  logic        lsu_wbck_i_err;
  logic [1:0]  oitf_ret_ptr;
  logic [9:0]  oitf_ret_rdidx;
  logic [1:0]  oitf_ret_rdwen;
  logic [1:0]  oitf_empty;
  logic        oitf_ret_ena;
  logic [1:0]  ret_thread_sel;
  logic        longp_wbck_o_valid;
  logic        longp_wbck_o_ready;
  logic [31:0] longp_wbck_o_wdat;
  logic [4:0]  longp_wbck_o_rdidx;
  logic        longp_wbck_o_tid;
  logic        longp_excp_o_valid;
  logic        longp_excp_o_ready;
  logic        longp_excp_o_tid;
`ifdef E203_LONGP_WBCK_STAT_EN
  logic [31:0] retire_cnt;
`endif

  always #5 clk = ~clk;

  e203_exu_longpwbck_mt #(.THREADS(2), .ITAG_W(1), .XLEN(32), .RFIDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_wbck_i_valid(lsu_wbck_i_valid), .lsu_wbck_i_ready(lsu_wbck_i_ready),
    .lsu_wbck_i_wdat(lsu_wbck_i_wdat), .lsu_wbck_i_itag(lsu_wbck_i_itag),
    .lsu_wbck_i_tid(lsu_wbck_i_tid), .lsu_wbck_i_err(lsu_wbck_i_err),
    .oitf_ret_ptr(oitf_ret_ptr), .oitf_ret_rdidx(oitf_ret_rdidx),
    .oitf_ret_rdwen(oitf_ret_rdwen), .oitf_empty(oitf_empty),
    .oitf_ret_ena(oitf_ret_ena), .ret_thread_sel(ret_thread_sel),
    .longp_wbck_o_valid(longp_wbck_o_valid), .longp_wbck_o_ready(longp_wbck_o_ready),
    .longp_wbck_o_wdat(longp_wbck_o_wdat), .longp_wbck_o_rdidx(longp_wbck_o_rdidx),
    .longp_wbck_o_tid(longp_wbck_o_tid),
    .longp_excp_o_valid(longp_excp_o_valid), .longp_excp_o_ready(longp_excp_o_ready),
    .longp_excp_o_tid(longp_excp_o_tid)
`ifdef E203_LONGP_WBCK_STAT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  typedef struct {
    logic        lv, tid, itag, err;
    logic [31:0] wdat;
    logic [1:0]  ptr, rdwen, empty;
    logic        wr, er;
    logic        x_lrdy, x_wv, x_ev;
    logic [1:0]  x_sel;
    logic        x_tid;
    logic [31:0] x_wdat;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic lv, tid, itag, err, input logic [31:0] wdat,
                              input logic [1:0] ptr, rdwen, empty, input logic wr, er,
                              input logic x_lrdy, x_wv, x_ev, input logic [1:0] x_sel,
                              input logic x_tid, input logic [31:0] x_wdat);
    vec_t v;
    v.lv = lv; v.tid = tid; v.itag = itag; v.err = err; v.wdat = wdat;
    v.ptr = ptr; v.rdwen = rdwen; v.empty = empty; v.wr = wr; v.er = er;
    v.x_lrdy = x_lrdy; v.x_wv = x_wv; v.x_ev = x_ev; v.x_sel = x_sel;
    v.x_tid = x_tid; v.x_wdat = x_wdat;
    return v;
  endfunction

  task automatic apply(input int idx, input vec_t v);
    logic ok;
    logic [4:0] x_rd;
    @(negedge clk);
    lsu_wbck_i_valid = v.lv; lsu_wbck_i_tid = v.tid; lsu_wbck_i_itag = v.itag;
    lsu_wbck_i_err = v.err; lsu_wbck_i_wdat = v.wdat; oitf_ret_ptr = v.ptr;
    oitf_ret_rdwen = v.rdwen; oitf_empty = v.empty;
    longp_wbck_o_ready = v.wr; longp_excp_o_ready = v.er;
    #1;
    x_rd = v.x_tid ? 5'd9 : 5'd5;
    ok = (lsu_wbck_i_ready === v.x_lrdy) && (longp_wbck_o_valid === v.x_wv) &&
         (longp_excp_o_valid === v.x_ev) && (oitf_ret_ena === (|v.x_sel)) &&
         (ret_thread_sel === v.x_sel);
    if (v.x_wv)
      ok = ok && (longp_wbck_o_tid === v.x_tid) && (longp_wbck_o_wdat === v.x_wdat) &&
           (longp_wbck_o_rdidx === x_rd);
    if (v.x_ev)
      ok = ok && (longp_excp_o_tid === v.x_tid);
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL vec%0d: got rdy=%b wv=%b ev=%b ena=%b sel=%b wtid=%b etid=%b wdat=%h rd=%0d, want rdy=%b wv=%b ev=%b sel=%b tid=%b wdat=%h rd=%0d",
               idx, lsu_wbck_i_ready, longp_wbck_o_valid, longp_excp_o_valid, oitf_ret_ena,
               ret_thread_sel, longp_wbck_o_tid, longp_excp_o_tid, longp_wbck_o_wdat,
               longp_wbck_o_rdidx, v.x_lrdy, v.x_wv, v.x_ev, v.x_sel, v.x_tid, v.x_wdat, x_rd);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  initial begin
    // Fields: lv tid itag err wdat | ptr rdwen empty wr er | x_lrdy x_wv x_ev x_sel x_tid x_wdat
    tbl[0]  = mk(0,0,0,0,32'h0,        2'b00,2'b11,2'b00,1,1, 1,0,0,2'b00,0,32'h0);
    // Both threads eligible at once, thread 0 has priority
    tbl[1]  = mk(1,0,0,0,32'h11110000, 2'b00,2'b11,2'b11,1,1, 1,0,0,2'b00,0,32'h0);
    tbl[2]  = mk(1,1,0,0,32'h22220000, 2'b00,2'b11,2'b11,1,1, 1,0,0,2'b00,0,32'h0);
    tbl[3]  = mk(0,0,0,0,32'h0,        2'b00,2'b11,2'b00,1,1, 0,1,0,2'b01,0,32'h11110000);
    tbl[4]  = mk(0,1,0,0,32'h0,        2'b00,2'b11,2'b00,1,1, 0,1,0,2'b10,1,32'h22220000);
    tbl[5]  = mk(0,0,0,0,32'h0,        2'b00,2'b11,2'b00,1,1, 1,0,0,2'b00,0,32'h0);
    // Single load, one-cycle latency
    tbl[6]  = mk(1,0,0,0,32'h12345678, 2'b00,2'b11,2'b00,1,1, 1,0,0,2'b00,0,32'h0);
    tbl[7]  = mk(0,0,0,0,32'h0,        2'b00,2'b11,2'b00,1,1, 0,1,0,2'b01,0,32'h12345678);
    // Both eligible again, pointer now favours thread 1
    tbl[8]  = mk(1,0,0,0,32'h33330000, 2'b00,2'b11,2'b11,1,1, 1,0,0,2'b00,0,32'h0);
    tbl[9]  = mk(1,1,0,0,32'h44440000, 2'b00,2'b11,2'b11,1,1, 1,0,0,2'b00,0,32'h0);
    tbl[10] = mk(0,1,0,0,32'h0,        2'b00,2'b11,2'b00,1,1, 0,1,0,2'b10,1,32'h44440000);
    tbl[11] = mk(0,0,0,0,32'h0,        2'b00,2'b11,2'b00,1,1, 0,1,0,2'b01,0,32'h33330000);
    // Back-pressure for 3 cycles; thread 1 arrives mid-stall and must not steal the grant
    tbl[12] = mk(1,0,0,0,32'hAAAA0001, 2'b00,2'b11,2'b00,1,1, 1,0,0,2'b00,0,32'h0);
    tbl[13] = mk(0,0,0,0,32'h0,        2'b00,2'b11,2'b00,0,1, 0,1,0,2'b00,0,32'hAAAA0001);
    tbl[14] = mk(1,1,0,0,32'hBBBB0002, 2'b00,2'b11,2'b00,0,1, 1,1,0,2'b00,0,32'hAAAA0001);
    tbl[15] = mk(0,1,0,0,32'h0,        2'b00,2'b11,2'b00,0,1, 0,1,0,2'b00,0,32'hAAAA0001);
    tbl[16] = mk(0,0,0,0,32'h0,        2'b00,2'b11,2'b00,1,1, 0,1,0,2'b01,0,32'hAAAA0001);
    tbl[17] = mk(0,1,0,0,32'h0,        2'b00,2'b11,2'b00,1,1, 0,1,0,2'b10,1,32'hBBBB0002);
    // Tag mismatch on thread 0 does not block thread 1
    tbl[18] = mk(1,0,1,0,32'hCCCC0003, 2'b00,2'b11,2'b00,1,1, 1,0,0,2'b00,0,32'h0);
    tbl[19] = mk(1,1,0,0,32'hDDDD0004, 2'b00,2'b11,2'b00,1,1, 1,0,0,2'b00,0,32'h0);
    tbl[20] = mk(0,0,0,0,32'h0,        2'b00,2'b11,2'b00,1,1, 0,1,0,2'b10,1,32'hDDDD0004);
    tbl[21] = mk(0,0,0,0,32'h0,        2'b00,2'b11,2'b00,1,1, 0,0,0,2'b00,0,32'h0);
    // Thread 0 matches now; error load accepted on thread 1 in the same cycle
    tbl[22] = mk(1,1,0,1,32'h0,        2'b01,2'b11,2'b00,1,1, 1,1,0,2'b01,0,32'hCCCC0003);
    tbl[23] = mk(0,1,0,0,32'h0,        2'b00,2'b11,2'b00,1,0, 0,0,1,2'b00,1,32'h0);
    tbl[24] = mk(0,1,0,0,32'h0,        2'b00,2'b11,2'b00,1,1, 0,0,1,2'b10,1,32'h0);
    // No rd write: retires with no output valid
    tbl[25] = mk(1,0,0,0,32'h00005555, 2'b00,2'b10,2'b00,1,1, 1,0,0,2'b00,0,32'h0);
    tbl[26] = mk(0,0,0,0,32'h0,        2'b00,2'b10,2'b00,1,1, 0,0,0,2'b01,0,32'h0);
    tbl[27] = mk(0,0,0,0,32'h0,        2'b00,2'b11,2'b00,1,1, 1,0,0,2'b00,0,32'h0);

    rst_n = 1'b0;
    lsu_wbck_i_valid = 0; lsu_wbck_i_tid = 0; lsu_wbck_i_itag = 0; lsu_wbck_i_err = 0;
    lsu_wbck_i_wdat = 0; oitf_ret_ptr = 0; oitf_ret_rdidx = {5'd9, 5'd5};
    oitf_ret_rdwen = 2'b11; oitf_empty = 2'b00;
    longp_wbck_o_ready = 1; longp_excp_o_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {27'd0, lsu_wbck_i_ready, longp_wbck_o_valid, longp_excp_o_valid,
                          oitf_ret_ena, |ret_thread_sel}, 32'h10);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) apply(i, tbl[i]);

`ifdef E203_LONGP_WBCK_STAT_EN
    check("retire_cnt", retire_cnt, {16'd5, 16'd6});
`endif

    // Reset while a held writeback is pending
    @(negedge clk);
    lsu_wbck_i_valid = 1; lsu_wbck_i_tid = 0; lsu_wbck_i_itag = 0; lsu_wbck_i_err = 0;
    lsu_wbck_i_wdat = 32'h77778888; oitf_ret_rdwen = 2'b11; longp_wbck_o_ready = 0;
    @(negedge clk);
    lsu_wbck_i_valid = 0;
    #1;
    check("hold_before_rst", {31'd0, longp_wbck_o_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_hold", {28'd0, longp_wbck_o_valid, longp_excp_o_valid, ret_thread_sel}, 32'd0);
    check("rst_no_ret", {31'd0, oitf_ret_ena}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    longp_wbck_o_ready = 1;
    @(negedge clk);
    #1;
    check("ready_after_rst", {30'd0, lsu_wbck_i_ready, longp_wbck_o_valid}, 32'd2);
`ifdef E203_LONGP_WBCK_STAT_EN
    check("retire_cnt_rst", retire_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/e203_exu_longpwbck_mt.md
Name: e203_exu_longpwbck_mt

Overview:
Multithreaded long-pipe writeback collector sitting directly downstream of the per-thread OITF bank. It accepts LSU long-pipe responses tagged with thread id and ITAG, and holds each in a per-thread one-entry buffer. It round-robins eligible threads onto the single regfile writeback and exception ports. On each completed writeback it drives the OITF retire strobe plus a one-hot thread select to free the oldest entry of that thread.

Parameters:
THREADS, 2, number of hardware threads (design supports exactly 2)
ITAG_W, 1, instruction tag width (matches E203_ITAG_WIDTH)
XLEN, 32, writeback data width
RFIDX_W, 5, register index width

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
lsu_wbck_i_valid  in  1  LSU response valid
lsu_wbck_i_ready  out  1  LSU response accepted
lsu_wbck_i_wdat  in  XLEN  load/AMO result
lsu_wbck_i_itag  in  ITAG_W  OITF tag of the response
lsu_wbck_i_tid  in  1  owning thread
lsu_wbck_i_err  in  1  bus error flag
oitf_ret_ptr  in  THREADS*ITAG_W  per-thread OITF retire pointer, thread 0 in LSBs
oitf_ret_rdidx  in  THREADS*RFIDX_W  per-thread rd index of the oldest entry
oitf_ret_rdwen  in  THREADS  per-thread rd-write flag of the oldest entry
oitf_empty  in  THREADS  per-thread OITF empty
oitf_ret_ena  out  1  retire strobe to OITF bank
ret_thread_sel  out  THREADS  one-hot thread being retired
longp_wbck_o_valid  out  1  regfile write request
longp_wbck_o_ready  in  1  regfile write accepted
longp_wbck_o_wdat  out  XLEN  write data
longp_wbck_o_rdidx  out  RFIDX_W  destination register
longp_wbck_o_tid  out  1  thread of the write
longp_excp_o_valid  out  1  exception report request
longp_excp_o_ready  in  1  exception accepted
longp_excp_o_tid  out  1  faulting thread

Behaviour:
- Clock is clk. Reset is asynchronous, active-low on rst_n. All buffers are invalid at reset.
- Reset output values: lsu_wbck_i_ready=1, all valids=0, oitf_ret_ena=0, ret_thread_sel=0. The round-robin pointer resets so thread 0 has priority.
- Each thread has a buffer {vld, itag, wdat, err}.
- lsu_wbck_i_ready = ~buf_vld[lsu_wbck_i_tid]. A freed buffer is not refilled in its freeing cycle; ready rises the next cycle.
- Accept (valid&ready) loads buf[tid] at the clock edge. The entry is not eligible until the following cycle, so minimum latency from accept to output valid is 1 cycle.
- Thread t is eligible when buf_vld[t] & ~oitf_empty[t] & (buf_itag[t]==oitf_ret_ptr[t]).
- A valid entry that is not eligible (tag mismatch, or OITF empty) holds indefinitely. It never blocks the other thread.
- Arbitration is round-robin over eligible threads; the winner is grant[t]. The pointer advances to the other thread only on a completed retire. Grant is combinational and must not change while an output valid is held without ready.
- For the granted thread t:
  - err=1: longp_excp_o_valid=1, longp_wbck_o_valid=0. Completion is longp_excp_o_ready.
  - err=0 and oitf_ret_rdwen[t]=1: longp_wbck_o_valid=1, with rdidx from oitf_ret_rdidx[t]. Completion is longp_wbck_o_ready.
  - err=0 and rdwen=0: completes in the same cycle with no output valid.
- On completion: oitf_ret_ena=1 and ret_thread_sel=grant (one-hot) in that cycle. buf_vld[t] clears at the edge.
- ret_thread_sel is all-zero whenever oitf_ret_ena=0.
- Both threads eligible in the same cycle: only one completes per cycle, and the other waits at least one cycle.
- Accepting into thread A while thread B completes is allowed in the same cycle.
- Reset asserted mid-handshake drops buffered entries with no retire strobe.

Optional Feature:
E203_LONGP_WBCK_STAT_EN
- Defined: adds output retire_cnt (THREADS*16 bits), one 16-bit counter per thread. A counter increments on each oitf_ret_ena with that thread selected, wraps 0xFFFF->0, and resets to 0.
- Undefined: the port and counters are absent and all other behaviour is identical.

Test Plan:
- Single load: tid0 itag0 wdat=0x12345678, ret_ptr0=0, rdwen0=1, rdidx0=5, wbck_ready=1 -> output valid 1 cycle after accept, wdat=0x12345678, rdidx=5, oitf_ret_ena=1, ret_thread_sel=2'b01.
- Back-pressure: same as above with wbck_ready=0 for 3 cycles -> valid held stable 3 cycles, no retire, lsu_wbck_i_ready[tid0]=0; retire occurs in the cycle ready=1.
- Both threads eligible with wbck_ready=1 -> thread0 retires first, thread1 next cycle (sel 01 then 10); repeat -> order alternates 10 then 01.
- Tag mismatch: buf0 itag=1, ret_ptr0=0 while thread1 has an eligible entry -> thread1 retires; thread0 holds until ret_ptr0=1.
- Error response: tid1 err=1 -> excp_o_valid=1, tid=1, wbck_o_valid=0; retire with sel=10 on excp_ready. Also rdwen=0 -> retire in the first eligible cycle with no output valid.
- Reset mid-hold (buf0 valid, wbck_ready=0), assert rst_n=0 -> all valids 0 immediately, lsu_wbck_i_ready=1 after release; with STAT_EN, counters read 0.
